// File: rtl/log_capture.sv
// Triggered multi-channel sample logger: decimated samples are stored in a block RAM,
// either one-shot after the trigger or circularly with a pre-trigger window.
module log_capture #(
    parameter int NB_DATA  = 13,
    parameter int N_CHAN   = 2,
    parameter int NB_ADDR  = 11,
    parameter int PRE_TRIG = 512
) (
    input  logic                      clock,
    input  logic                      i_reset,
    input  logic [N_CHAN*NB_DATA-1:0] i_data,
    input  logic                      i_valid,
    input  logic                      i_arm,
    input  logic                      i_trigger,
    input  logic                      i_mode,
    input  logic [7:0]                i_decim,
    input  logic [NB_ADDR-1:0]        i_read_addr,
    output logic [N_CHAN*NB_DATA-1:0] o_read_data,
    output logic                      o_busy,
    output logic                      o_full,
    output logic [NB_ADDR-1:0]        o_trig_addr,
    output logic [NB_ADDR:0]          o_count
);
    localparam int NB_WORD = N_CHAN * NB_DATA;
    localparam int DEPTH   = 1 << NB_ADDR;
    localparam logic [NB_ADDR:0]   COUNT_FULL = (NB_ADDR+1)'(DEPTH);
    localparam logic [NB_ADDR:0]   COUNT_PRE  = (NB_ADDR+1)'(PRE_TRIG);
    localparam logic [NB_ADDR-1:0] PRE_LAST   = NB_ADDR'(PRE_TRIG);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    // state is the FSM observation point for external checkers.
    state_t               state, state_n;
    logic                 arm_q, trig_q;
    logic                 arm_edge, trig_edge, accept;
    logic [7:0]           dec_cnt, dec_cnt_n;
    logic [7:0]           decim_l, decim_n;
    logic                 mode_l, mode_n;
    logic [NB_ADDR-1:0]   wr_addr, wr_addr_n;
    logic [NB_ADDR-1:0]   pre_cnt, pre_cnt_n;
    logic [NB_ADDR-1:0]   trig_addr_n;
    logic [NB_ADDR:0]     count_n;
    logic                 wr_en, busy_n, full_n;
    logic [NB_WORD-1:0]   mem [DEPTH];

    // i_valid qualifies i_data for exactly one cycle and there is no backpressure:
    // every valid sample is either stored or dropped by decimation/state.
    assign arm_edge  = i_arm & ~arm_q;
    assign trig_edge = i_trigger & ~trig_q;
    assign accept    = i_valid && (dec_cnt == 8'd0);

    always_comb begin
        state_n     = state;
        wr_addr_n   = wr_addr;
        pre_cnt_n   = pre_cnt;
        count_n     = o_count;
        trig_addr_n = o_trig_addr;
        mode_n      = mode_l;
        decim_n     = decim_l;
        dec_cnt_n   = dec_cnt;
        wr_en       = 1'b0;

        if (i_valid) dec_cnt_n = (dec_cnt >= decim_l) ? 8'd0 : dec_cnt + 8'd1;

        if (arm_edge) begin
            state_n   = ARMED;
            wr_addr_n = '0;
            pre_cnt_n = '0;
            count_n   = '0;
            mode_n    = i_mode;
            decim_n   = i_decim;
            dec_cnt_n = 8'd0;
        end else begin
            case (state)
                ARMED: begin
                    // Pre-trigger mode ignores triggers until the history window is full.
                    if (trig_edge && (!mode_l || pre_cnt == PRE_LAST)) begin
                        state_n     = CAPTURE;
                        trig_addr_n = wr_addr;
                        count_n     = mode_l ? COUNT_PRE : '0;
                        if (accept) begin
                            wr_en     = 1'b1;
                            wr_addr_n = wr_addr + 1'b1;
                            count_n   = count_n + 1'b1;
                        end
                        if (count_n == COUNT_FULL) state_n = DONE;
                    end else if (mode_l && accept) begin
                        wr_en     = 1'b1;
                        wr_addr_n = wr_addr + 1'b1;
                        if (pre_cnt != PRE_LAST) pre_cnt_n = pre_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    if (accept) begin
                        wr_en     = 1'b1;
                        wr_addr_n = wr_addr + 1'b1;
                        count_n   = o_count + 1'b1;
                        if (count_n == COUNT_FULL) state_n = DONE;
                    end
                end
                default: ;
            endcase
        end

        if (!i_reset) wr_en = 1'b0;
        busy_n = (state_n == ARMED) || (state_n == CAPTURE);
        full_n = (state_n == DONE);
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            state       <= IDLE;
            // Loading the current level means a level held through reset is not an edge.
            arm_q       <= i_arm;
            trig_q      <= i_trigger;
            dec_cnt     <= 8'd0;
            decim_l     <= 8'd0;
            mode_l      <= 1'b0;
            wr_addr     <= '0;
            pre_cnt     <= '0;
            o_count     <= '0;
            o_trig_addr <= '0;
            o_busy      <= 1'b0;
            o_full      <= 1'b0;
        end else begin
            state       <= state_n;
            arm_q       <= i_arm;
            trig_q      <= i_trigger;
            dec_cnt     <= dec_cnt_n;
            decim_l     <= decim_n;
            mode_l      <= mode_n;
            wr_addr     <= wr_addr_n;
            pre_cnt     <= pre_cnt_n;
            o_count     <= count_n;
            o_trig_addr <= trig_addr_n;
            o_busy      <= busy_n;
            o_full      <= full_n;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= i_data;
    end

    // Read-before-write: a same-address collision returns the previous word.
    always_ff @(posedge clock) begin
        if (!i_reset) o_read_data <= '0;
        else          o_read_data <= mem[i_read_addr];
    end
endmodule

// File: tb/tb_log_capture.sv
// Self-checking bench for log_capture: control-vector table, directed ramp scenarios
// and randomized captures checked against a sample-list reference model.
module tb_log_capture;
    logic        clock;
    logic        i_reset;
    logic [25:0] i_data;
    logic        i_valid;
    logic        i_arm;
    logic        i_trigger;
    logic        i_mode;
    logic [7:0]  i_decim;
    logic [3:0]  i_read_addr;
    logic [25:0] o_read_data;
    logic        o_busy;
    logic        o_full;
    logic [3:0]  o_trig_addr;
    logic [4:0]  o_count;

    int n_cmp = 0;
    int n_err = 0;
    int ramp  = 0;

    log_capture #(.NB_DATA(13), .N_CHAN(2), .NB_ADDR(4), .PRE_TRIG(4)) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_arm       (i_arm),
        .i_trigger   (i_trigger),
        .i_mode      (i_mode),
        .i_decim     (i_decim),
        .i_read_addr (i_read_addr),
        .o_read_data (o_read_data),
        .o_busy      (o_busy),
        .o_full      (o_full),
        .o_trig_addr (o_trig_addr),
        .o_count     (o_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic arm;
        logic trig;
        logic valid;
        logic mode;
        logic exp_busy;
        logic exp_full;
        int   exp_count;
        logic chk_trig;
        int   exp_trig;
    } vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [25:0] pack(input int v);
        logic [12:0] c0;
        c0 = 13'(v);
        return {c0 ^ 13'h0abc, c0};
    endfunction

    task automatic ramp_tick();
        i_data = pack(ramp);
        ramp++;
        tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic read_chk(input string name, input int addr, input logic [25:0] exp);
        i_read_addr = 4'(addr);
        tick();
        chk(name, o_read_data, exp);
    endtask

    // Reference model: tracks the accepted-sample stream since the arm edge and derives
    // the stored image from it (sample i of the stream lands at address i mod 16).
    task automatic random_capture();
        logic        m;
        int          dec, vcnt, nacc, post, need, trig_w;
        bit          honoured, done, rise, v, acc;
        logic        t;
        logic [25:0] d;
        logic [25:0] exp_q[$];
        logic [25:0] img[16];

        m   = 1'($urandom_range(0, 1));
        dec = $urandom_range(0, 3);
        i_mode = m; i_decim = 8'(dec); i_trigger = 1'b0;
        i_valid = 1'($urandom_range(0, 1)); i_data = 26'($urandom);
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        vcnt = 0; nacc = 0; post = 0; trig_w = 0; honoured = 0; done = 0;
        need = m ? 12 : 16;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            v    = ($urandom_range(0, 3) != 0);
            t    = ($urandom_range(0, 4) == 0) ? ~i_trigger : i_trigger;
            d    = 26'($urandom);
            rise = t && !i_trigger;
            acc  = v && (vcnt % (dec + 1) == 0);
            if (v) vcnt++;
            if (!honoured && rise && (!m || nacc >= 4)) begin
                honoured = 1;
                trig_w   = exp_q.size();
            end
            if (acc) begin
                if (honoured) begin
                    exp_q.push_back(d);
                    post++;
                end else if (m) begin
                    exp_q.push_back(d);
                end
                nacc++;
            end
            i_valid = v; i_trigger = t; i_data = d; i_read_addr = 4'($urandom);
            tick();
            done = (post == need);
            chk("rnd_busy", o_busy, !done);
            chk("rnd_full", o_full, done);
            chk("rnd_count", o_count, honoured ? ((m ? 4 : 0) + post) : 0);
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL rnd_timeout: got not-done expected done within 1000 cycles");
        end
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'($urandom_range(0, 1)); i_trigger = 1'($urandom_range(0, 1));
            i_data = 26'($urandom);
            tick();
            chk("rnd_hold_full", o_full, 1);
            chk("rnd_hold_count", o_count, 16);
            chk("rnd_trig_addr", o_trig_addr, 32'(trig_w % 16));
        end
        for (int i = 0; i < exp_q.size(); i++) img[i % 16] = exp_q[i];
        for (int a = 0; a < 16; a++) read_chk("rnd_ram", a, img[a]);
    endtask

    initial begin
        vec_t vecs[15];
        int   r0, r_e;

        vecs[0]  = '{0, 0, 1, 0, 0, 0, 0, 1, 0};
        vecs[1]  = '{1, 0, 1, 1, 1, 0, 0, 1, 0};
        vecs[2]  = '{1, 0, 1, 1, 1, 0, 0, 1, 0};
        vecs[3]  = '{1, 1, 1, 1, 1, 0, 0, 1, 0};
        vecs[4]  = '{0, 0, 1, 1, 1, 0, 0, 1, 0};
        vecs[5]  = '{0, 0, 0, 1, 1, 0, 0, 1, 0};
        vecs[6]  = '{0, 0, 1, 1, 1, 0, 0, 1, 0};
        vecs[7]  = '{0, 1, 1, 1, 1, 0, 5, 1, 4};
        vecs[8]  = '{0, 1, 1, 1, 1, 0, 6, 1, 4};
        vecs[9]  = '{0, 0, 0, 1, 1, 0, 6, 1, 4};
        vecs[10] = '{1, 0, 1, 0, 1, 0, 0, 0, 0};
        vecs[11] = '{1, 0, 1, 0, 1, 0, 0, 0, 0};
        vecs[12] = '{1, 1, 1, 0, 1, 0, 1, 1, 0};
        vecs[13] = '{1, 1, 1, 0, 1, 0, 2, 1, 0};
        vecs[14] = '{0, 0, 1, 0, 1, 0, 3, 1, 0};

        // Reset with arm/trigger held high through release
        i_reset = 1'b0; i_data = '0; i_valid = 1'b0; i_arm = 1'b1; i_trigger = 1'b1;
        i_mode = 1'b0; i_decim = 8'd0; i_read_addr = '0;
        repeat (3) tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_full", o_full, 0);
        chk("rst_count", o_count, 0);
        chk("rst_trig_addr", o_trig_addr, 0);
        chk("rst_read_data", o_read_data, 0);
        i_reset = 1'b1;
        tick();
        chk("held_arm_no_edge", o_busy, 0);
        tick();
        chk("held_arm_no_edge2", o_busy, 0);
        i_arm = 1'b0; i_trigger = 1'b0;
        tick();
        chk("arm_low_idle", o_busy, 0);

        // Control vectors: held arm, early pre-trigger ignored, abort, one-shot restart
        for (int i = 0; i < 15; i++) begin
            i_arm = vecs[i].arm; i_trigger = vecs[i].trig;
            i_valid = vecs[i].valid; i_mode = vecs[i].mode; i_decim = 8'd0;
            ramp_tick();
            chk("vec_busy", o_busy, vecs[i].exp_busy);
            chk("vec_full", o_full, vecs[i].exp_full);
            chk("vec_count", o_count, 32'(vecs[i].exp_count));
            if (vecs[i].chk_trig) chk("vec_trig_addr", o_trig_addr, 32'(vecs[i].exp_trig));
        end

        // One-shot, trigger at ramp value 100
        ramp = 90; i_mode = 1'b0; i_decim = 8'd0; i_valid = 1'b1; i_arm = 1'b1;
        ramp_tick();
        i_arm = 1'b0;
        while (ramp < 100) ramp_tick();
        i_trigger = 1'b1;
        ramp_tick();
        i_trigger = 1'b0;
        chk("os_first_count", o_count, 1);
        chk("os_trig_addr", o_trig_addr, 0);
        for (int k = 1; k <= 15; k++) begin
            ramp_tick();
            if (k == 14) begin
                chk("os_not_full_15", o_full, 0);
                chk("os_count_15", o_count, 15);
            end
        end
        chk("os_full", o_full, 1);
        chk("os_busy_off", o_busy, 0);
        chk("os_count_16", o_count, 16);
        repeat (3) ramp_tick();
        chk("os_done_hold", o_count, 16);
        for (int a = 0; a < 16; a++) read_chk("os_ram", a, pack(100 + a));

        // Pre-trigger: 10 samples then trigger, with a same-address read on the trigger write
        i_mode = 1'b1; r0 = ramp; i_arm = 1'b1;
        ramp_tick();
        i_arm = 1'b0;
        repeat (10) ramp_tick();
        i_trigger = 1'b1; i_read_addr = 4'd10;
        ramp_tick();
        i_trigger = 1'b0;
        chk("pt_trig_addr", o_trig_addr, 10);
        chk("pt_count", o_count, 5);
        chk("pt_read_old", o_read_data, pack(110));
        for (int k = 1; k <= 11; k++) begin
            ramp_tick();
            if (k == 10) chk("pt_not_full", o_full, 0);
        end
        chk("pt_full", o_full, 1);
        chk("pt_count_16", o_count, 16);
        for (int a = 0; a < 16; a++)
            read_chk("pt_ram", a, pack(a >= 6 ? r0 + 1 + a : r0 + 17 + a));

        // Decimation by 4 with i_valid held high
        i_mode = 1'b0; i_decim = 8'd3; r_e = ramp; i_arm = 1'b1;
        ramp_tick();
        i_arm = 1'b0; i_trigger = 1'b1;
        ramp_tick();
        i_trigger = 1'b0;
        chk("dec_count_first", o_count, 1);
        for (int k = 1; k <= 60; k++) begin
            ramp_tick();
            chk("dec_count", o_count, 32'(1 + k / 4));
        end
        chk("dec_full", o_full, 1);
        for (int a = 0; a < 16; a++) read_chk("dec_ram", a, pack(r_e + 1 + 4 * a));

        // Reset pulse at count 7
        i_decim = 8'd0; r0 = ramp; i_arm = 1'b1;
        ramp_tick();
        i_arm = 1'b0; i_trigger = 1'b1;
        ramp_tick();
        i_trigger = 1'b0;
        repeat (6) ramp_tick();
        chk("rp_count_7", o_count, 7);
        i_reset = 1'b0;
        ramp_tick();
        chk("rp_busy", o_busy, 0);
        chk("rp_full", o_full, 0);
        chk("rp_count", o_count, 0);
        chk("rp_trig_addr", o_trig_addr, 0);
        chk("rp_read_data", o_read_data, 0);
        i_reset = 1'b1;
        repeat (2) ramp_tick();
        chk("rp_idle", o_busy, 0);
        for (int a = 0; a < 7; a++) read_chk("rp_ram", a, pack(r0 + 1 + a));
        read_chk("rp_no_write", 7, pack(r_e + 29));

        // Arm held for 20 cycles during capture
        i_arm = 1'b1;
        ramp_tick();
        i_arm = 1'b0; i_trigger = 1'b1;
        ramp_tick();
        i_trigger = 1'b0;
        repeat (3) ramp_tick();
        chk("ah_count_4", o_count, 4);
        i_arm = 1'b1;
        for (int k = 0; k < 20; k++) begin
            ramp_tick();
            chk("ah_busy", o_busy, 1);
            chk("ah_count", o_count, 0);
        end
        i_arm = 1'b0;
        ramp_tick();
        chk("ah_still_armed", o_count, 0);
        i_trigger = 1'b1;
        ramp_tick();
        i_trigger = 1'b0;
        chk("ah_retrigger", o_count, 1);

        for (int n = 0; n < 8; n++) random_capture();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
